ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12, meaning RAM address bits (depth 2^ADDR_WIDTH).
REQ-002 SHALL have parameter DATA_WIDTH, default 4, meaning nibble width of each word.
REQ-003 SHALL have parameter NUM_CHANNELS, default 2, meaning auxiliary ports (video, debug), range 1..8.
REQ-004 SHALL have parameter CLEAR_ON_RESET, default 1, meaning zero-fill sweep after reset.
REQ-005 SHALL have port clk, input, 1, the single system clock.
REQ-006 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port cpu_write_en, input, 1, CPU write strobe.
REQ-008 SHALL have port cpu_read_en, input, 1, CPU read strobe.
REQ-009 SHALL have port cpu_addr, input, ADDR_WIDTH, CPU address.
REQ-010 SHALL have port cpu_write_data, input, DATA_WIDTH, CPU write data.
REQ-011 SHALL have port cpu_read_data, output, DATA_WIDTH, registered CPU read data.
REQ-012 SHALL have port cpu_ready, output, 1, high when the block accepts accesses.
REQ-013 SHALL have port aux_req, input, NUM_CHANNELS, per-channel request.
REQ-014 SHALL have port aux_write_en, input, NUM_CHANNELS, per-channel write qualifier.
REQ-015 SHALL have port aux_addr, input, NUM_CHANNELS*ADDR_WIDTH, packed channel addresses, channel i at [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-016 SHALL have port aux_write_data, input, NUM_CHANNELS*DATA_WIDTH, packed channel write data.
REQ-017 SHALL have port aux_grant, output, NUM_CHANNELS, one-hot combinational accept in the cycle served.
REQ-018 SHALL have port aux_valid, output, NUM_CHANNELS, one-hot read-data valid pulse.
REQ-019 SHALL have port aux_read_data, output, DATA_WIDTH, shared registered aux read data.

Function
REQ-020 SHALL perform at most one array access per clk cycle.
REQ-021 SHALL use states CLEAR and RUN; CLEAR entered on reset when CLEAR_ON_RESET=1, else RUN directly.
REQ-022 In CLEAR SHALL write zero to address counter value each cycle, counter 0 to 2^ADDR_WIDTH-1, then transition to RUN the cycle after writing the last address.
REQ-023 cpu_ready SHALL be low in CLEAR and high in RUN; CPU strobes and aux_req SHALL be ignored (no grant, no write) while cpu_ready low.
REQ-024 In RUN, a CPU access (cpu_write_en or cpu_read_en) SHALL take the cycle with absolute priority over aux channels; cpu_write_en wins if both strobes high.
REQ-025 CPU read SHALL update cpu_read_data on the next rising clk edge (1-cycle latency); cpu_read_data SHALL hold its value otherwise, including during writes.
REQ-026 When the CPU is idle, SHALL grant the lowest-index requesting channel at or after the round-robin pointer; pointer SHALL advance to granted index+1 (mod NUM_CHANNELS) after each grant.
REQ-027 Granted aux write SHALL store aux_write_data of that channel; granted aux read SHALL load aux_read_data and pulse that channel's aux_valid for exactly one cycle, next edge.
REQ-028 aux_valid SHALL not pulse for aux writes; aux_read_data SHALL hold between reads.
REQ-029 Read of an address written in the previous cycle SHALL return the new data; no same-cycle write/read collision exists (REQ-020).
REQ-030 Address arithmetic SHALL be unsigned ADDR_WIDTH bits; clear counter wraps only once by construction.
REQ-031 Aux requesters SHALL hold req/addr/data until granted; starvation under continuous CPU traffic is permitted.

Reset
REQ-032 On reset_n low, asynchronously: cpu_read_data=0, aux_read_data=0, aux_valid=0, round-robin pointer=0, clear counter=0, state=CLEAR (or RUN if CLEAR_ON_RESET=0).
REQ-033 Reset mid-CLEAR SHALL restart the sweep from address 0.
REQ-034 Array contents SHALL not be reset asynchronously; only CLEAR zeroes them.

Structure
REQ-035 State enum (CLEAR, RUN) SHALL live in the shared CPU package alongside existing CPU typedefs.
REQ-036 Storage SHALL be a sub-module ram_array (single-port, synchronous write and registered read, parametrised ADDR_WIDTH/DATA_WIDTH).

Verification
REQ-037 Reset then idle 4096 cycles, CLEAR_ON_RESET=1 -> cpu_ready rises on cycle 4097; read 0xFFF returns 0.
REQ-038 CPU write 0x222<=0x5, next cycle CPU read 0x222 -> cpu_read_data=0x5 one edge later.
REQ-039 aux_req=2'b11 both reads, CPU idle -> grants ch0 then ch1 on consecutive cycles, each aux_valid one cycle, data correct.
REQ-040 CPU reads every cycle for 10 cycles with aux_req[0] high -> no aux_grant until CPU idle, then grant ch0 immediately.
REQ-041 Assert reset_n low at clear address 0x100 -> after release sweep restarts at 0, cpu_ready high after 4096 cycles.
REQ-042 aux ch1 write 0x333<=0xA, then CPU read 0x333 -> 0xA, aux_valid stays 0 for the write.

Source files
------------

// File: rtl/ram_arbiter_pkg.sv
// Shared CPU-side types for the RAM arbiter: CPU strobe decode and
// arbiter sequencing states.
package ram_arbiter_pkg;

  localparam int MAX_CHANNELS = 8;

  typedef enum logic [1:0] {
    CPU_IDLE  = 2'd0,
    CPU_READ  = 2'd1,
    CPU_WRITE = 2'd2
  } cpu_op_t;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } arb_state_t;

  // Write wins when both strobes are raised together.
  function automatic cpu_op_t cpu_decode(input logic write_en, input logic read_en);
    if (write_en) return CPU_WRITE;
    if (read_en) return CPU_READ;
    return CPU_IDLE;
  endfunction

endpackage

// File: rtl/ram_arbiter_ram_array.sv
// Single-port storage with synchronous write and registered read.
// Contents are deliberately not reset; the arbiter zero-fills them.
module ram_array #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  write_en,
  input  logic                  read_en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic [DATA_WIDTH-1:0] read_data
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (write_en) mem[addr] <= write_data;
    if (read_en) read_data <= mem[addr];
  end

endmodule

// File: rtl/ram_arbiter.sv
// One-access-per-cycle RAM arbiter: CPU has absolute priority, aux
// channels share the leftover cycles round-robin; optional zero-fill after reset.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH     = 12,
  parameter int DATA_WIDTH     = 4,
  parameter int NUM_CHANNELS   = 2,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             cpu_write_en,
  input  logic                             cpu_read_en,
  input  logic [ADDR_WIDTH-1:0]            cpu_addr,
  input  logic [DATA_WIDTH-1:0]            cpu_write_data,
  output logic [DATA_WIDTH-1:0]            cpu_read_data,
  output logic                             cpu_ready,
  input  logic [NUM_CHANNELS-1:0]          aux_req,
  input  logic [NUM_CHANNELS-1:0]          aux_write_en,
  input  logic [NUM_CHANNELS*ADDR_WIDTH-1:0] aux_addr,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] aux_write_data,
  output logic [NUM_CHANNELS-1:0]          aux_grant,
  output logic [NUM_CHANNELS-1:0]          aux_valid,
  output logic [DATA_WIDTH-1:0]            aux_read_data
);

  localparam int PTR_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
  localparam arb_state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

  arb_state_t state, state_nxt;
  cpu_op_t cpu_op;
  logic [ADDR_WIDTH-1:0] clear_cnt, clear_cnt_nxt;
  logic [PTR_W-1:0] rr_ptr, rr_ptr_nxt;
  logic [PTR_W-1:0] scan_idx, grant_idx;
  logic grant_any;

  logic mem_we, mem_re;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata, mem_rdata;

  logic cpu_rd_start, cpu_rd_q, aux_rd_q;
  logic [NUM_CHANNELS-1:0] aux_rd_start;
  logic [DATA_WIDTH-1:0] cpu_hold, aux_hold;

  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NUM_CHANNELS) sum = sum - NUM_CHANNELS;
    return PTR_W'(sum);
  endfunction

  assign cpu_op    = cpu_decode(cpu_write_en, cpu_read_en);
  assign cpu_ready = (state == ST_RUN);

  // Search starts at the pointer and wraps, so the first hit is the winner.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      scan_idx = wrap_add(rr_ptr, k);
      if (!grant_any && aux_req[scan_idx]) begin
        grant_any = 1'b1;
        grant_idx = scan_idx;
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    clear_cnt_nxt = clear_cnt;
    rr_ptr_nxt    = rr_ptr;
    mem_we        = 1'b0;
    mem_re        = 1'b0;
    mem_addr      = cpu_addr;
    mem_wdata     = cpu_write_data;
    aux_grant     = '0;
    cpu_rd_start  = 1'b0;
    aux_rd_start  = '0;
    unique case (state)
      ST_CLEAR: begin
        mem_we        = 1'b1;
        mem_addr      = clear_cnt;
        mem_wdata     = '0;
        clear_cnt_nxt = clear_cnt + 1'b1;
        if (clear_cnt == LAST_ADDR) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (cpu_op == CPU_WRITE) begin
          mem_we = 1'b1;
        end else if (cpu_op == CPU_READ) begin
          mem_re       = 1'b1;
          cpu_rd_start = 1'b1;
        end else if (grant_any) begin
          aux_grant[grant_idx] = 1'b1;
          mem_addr  = aux_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
          mem_wdata = aux_write_data[grant_idx*DATA_WIDTH +: DATA_WIDTH];
          if (aux_write_en[grant_idx]) begin
            mem_we = 1'b1;
          end else begin
            mem_re = 1'b1;
            aux_rd_start[grant_idx] = 1'b1;
          end
          rr_ptr_nxt = wrap_add(grant_idx, 1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= RESET_STATE;
      clear_cnt <= '0;
      rr_ptr    <= '0;
    end else begin
      state     <= state_nxt;
      clear_cnt <= clear_cnt_nxt;
      rr_ptr    <= rr_ptr_nxt;
    end
  end

  // The array's read register is shared; these flags route it to the
  // requester for one cycle, after which the hold registers take over.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cpu_rd_q  <= 1'b0;
      aux_rd_q  <= 1'b0;
      aux_valid <= '0;
      cpu_hold  <= '0;
      aux_hold  <= '0;
    end else begin
      cpu_rd_q  <= cpu_rd_start;
      aux_rd_q  <= |aux_rd_start;
      aux_valid <= aux_rd_start;
      if (cpu_rd_q) cpu_hold <= mem_rdata;
      if (aux_rd_q) aux_hold <= mem_rdata;
    end
  end

  assign cpu_read_data = cpu_rd_q ? mem_rdata : cpu_hold;
  assign aux_read_data = aux_rd_q ? mem_rdata : aux_hold;

  ram_array #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_ram_array (
    .clk       (clk),
    .write_en  (mem_we),
    .read_en   (mem_re),
    .addr      (mem_addr),
    .write_data(mem_wdata),
    .read_data (mem_rdata)
  );

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: a memory/round-robin reference model
// predicts grants and read results; a monitor checks outputs every cycle.
module tb_ram_arbiter;

  localparam int AW    = 12;
  localparam int DW    = 4;
  localparam int NCH   = 2;
  localparam int DEPTH = 4096;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic cpu_write_en, cpu_read_en;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_write_data, cpu_read_data;
  logic cpu_ready;
  logic [NCH-1:0] aux_req, aux_write_en, aux_grant, aux_valid;
  logic [NCH*AW-1:0] aux_addr;
  logic [NCH*DW-1:0] aux_write_data;
  logic [DW-1:0] aux_read_data;

  always #5 clk = ~clk;

  ram_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_CHANNELS(NCH), .CLEAR_ON_RESET(1)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_write_en(cpu_write_en), .cpu_read_en(cpu_read_en),
    .cpu_addr(cpu_addr), .cpu_write_data(cpu_write_data),
    .cpu_read_data(cpu_read_data), .cpu_ready(cpu_ready),
    .aux_req(aux_req), .aux_write_en(aux_write_en),
    .aux_addr(aux_addr), .aux_write_data(aux_write_data),
    .aux_grant(aux_grant), .aux_valid(aux_valid), .aux_read_data(aux_read_data)
  );

  typedef struct {
    int due;
    int ch;
    logic [DW-1:0] data;
  } exp_t;

  exp_t cpu_q[$];
  exp_t aux_q[$];
  logic [DW-1:0] model_mem [DEPTH];
  int model_ptr, clear_left, last_grant;
  int cyc = 0;
  logic [NCH-1:0] seen_grant;
  logic [DW-1:0] exp_cpu, exp_aux;
  bit mon_en;
  int n_cmp, n_fail;

  bit pend [NCH];
  logic pwe [NCH];
  logic [AW-1:0] paddr [NCH];
  logic [DW-1:0] pdata [NCH];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic set_idle();
    cpu_write_en = 1'b0; cpu_read_en = 1'b0;
    cpu_addr = '0; cpu_write_data = '0;
    aux_req = '0; aux_write_en = '0; aux_addr = '0; aux_write_data = '0;
  endtask

  task automatic apply_aux();
    for (int c = 0; c < NCH; c++) begin
      aux_req[c] = pend[c];
      aux_write_en[c] = pend[c] ? pwe[c] : 1'b0;
      aux_addr[c*AW +: AW] = paddr[c];
      aux_write_data[c*DW +: DW] = pdata[c];
    end
  endtask

  // Reference: one access per cycle, CPU first (write over read), else
  // first requester found scanning from the pointer.
  task automatic model_eval();
    logic [NCH-1:0] exp_gnt;
    int g;
    exp_gnt = '0;
    g = -1;
    seen_grant = aux_grant;
    chk("cpu_ready", {31'd0, cpu_ready}, {31'd0, clear_left == 0});
    if (clear_left == 0) begin
      if (cpu_write_en) begin
        model_mem[cpu_addr] = cpu_write_data;
      end else if (cpu_read_en) begin
        cpu_q.push_back('{cyc + 1, 0, model_mem[cpu_addr]});
      end else begin
        for (int k = 0; k < NCH; k++) begin
          int c;
          c = (model_ptr + k) % NCH;
          if (g < 0 && aux_req[c]) g = c;
        end
        if (g >= 0) begin
          exp_gnt[g] = 1'b1;
          model_ptr = (g + 1) % NCH;
          if (aux_write_en[g]) model_mem[aux_addr[g*AW +: AW]] = aux_write_data[g*DW +: DW];
          else aux_q.push_back('{cyc + 1, g, model_mem[aux_addr[g*AW +: AW]]});
        end
      end
    end else begin
      clear_left--;
    end
    chk("aux_grant", {30'd0, aux_grant}, {30'd0, exp_gnt});
    last_grant = g;
  endtask

  task automatic step();
    @(negedge clk);
    model_eval();
    @(posedge clk);
    #1;
  endtask

  task automatic monitor_loop();
    forever begin
      @(negedge clk);
      if (mon_en) begin
        logic [NCH-1:0] ev;
        ev = '0;
        while (cpu_q.size() > 0 && cpu_q[0].due <= cyc) begin
          exp_cpu = cpu_q[0].data;
          void'(cpu_q.pop_front());
        end
        while (aux_q.size() > 0 && aux_q[0].due <= cyc) begin
          ev[aux_q[0].ch] = 1'b1;
          exp_aux = aux_q[0].data;
          void'(aux_q.pop_front());
        end
        chk("cpu_read_data", {28'd0, cpu_read_data}, {28'd0, exp_cpu});
        chk("aux_read_data", {28'd0, aux_read_data}, {28'd0, exp_aux});
        chk("aux_valid", {30'd0, aux_valid}, {30'd0, ev});
      end
    end
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    set_idle();
    reset_n = 1'b0;
    #3;
    chk("rst cpu_read_data", {28'd0, cpu_read_data}, 32'd0);
    chk("rst aux_read_data", {28'd0, aux_read_data}, 32'd0);
    chk("rst aux_valid", {30'd0, aux_valid}, 32'd0);
    chk("rst cpu_ready", {31'd0, cpu_ready}, 32'd0);
    cpu_q.delete();
    aux_q.delete();
    exp_cpu = '0;
    exp_aux = '0;
    model_ptr = 0;
    for (int c = 0; c < NCH; c++) pend[c] = 1'b0;
    for (int a = 0; a < DEPTH; a++) model_mem[a] = '0;
    clear_left = DEPTH;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    mon_en = 1'b1;
  endtask

  // Strobes raised during the sweep must be ignored.
  task automatic wait_clear_with_junk();
    cpu_write_en = 1'b1; cpu_addr = 12'hFFF; cpu_write_data = 4'hF;
    aux_req = '1; aux_write_en = '1; aux_addr = '1; aux_write_data = '1;
    while (clear_left > 0) step();
    set_idle();
    step();
  endtask

  task automatic cpu_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    cpu_write_en = 1'b1; cpu_read_en = 1'b0; cpu_addr = a; cpu_write_data = d;
    step();
    cpu_write_en = 1'b0;
  endtask

  task automatic cpu_rd(input logic [AW-1:0] a);
    cpu_write_en = 1'b0; cpu_read_en = 1'b1; cpu_addr = a;
    step();
    cpu_read_en = 1'b0;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return AW'($urandom);
    return AW'($urandom_range(0, 15));
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    n_cmp = 0;
    n_fail = 0;
    mon_en = 1'b0;
    exp_cpu = '0;
    exp_aux = '0;
    for (int c = 0; c < NCH; c++) begin
      pend[c] = 1'b0; pwe[c] = 1'b0; paddr[c] = '0; pdata[c] = '0;
    end
    set_idle();
    fork
      monitor_loop();
    join_none

    // Reset, full sweep, then the top address reads back zero.
    do_reset();
    wait_clear_with_junk();
    cpu_rd(12'hFFF);
    chk("clear rd fff", {28'd0, cpu_read_data}, 32'd0);

    cpu_wr(12'h222, 4'h5);
    cpu_rd(12'h222);
    chk("cpu rd 222", {28'd0, cpu_read_data}, 32'h5);

    // Two aux reads requested together, CPU idle.
    cpu_wr(12'h010, 4'h3);
    cpu_wr(12'h011, 4'hC);
    pend[0] = 1'b1; pwe[0] = 1'b0; paddr[0] = 12'h010;
    pend[1] = 1'b1; pwe[1] = 1'b0; paddr[1] = 12'h011;
    apply_aux();
    step();
    chk("rr first grant", {30'd0, seen_grant}, 32'b01);
    pend[0] = 1'b0;
    apply_aux();
    step();
    chk("rr second grant", {30'd0, seen_grant}, 32'b10);
    pend[1] = 1'b0;
    apply_aux();
    step();

    // CPU streaming reads starve aux ch0 until it goes idle.
    pend[0] = 1'b1; pwe[0] = 1'b0; paddr[0] = 12'h011;
    apply_aux();
    for (int n = 0; n < 10; n++) begin
      cpu_read_en = 1'b1;
      cpu_addr = rand_addr();
      step();
      chk("cpu starve grant", {30'd0, seen_grant}, 32'd0);
    end
    cpu_read_en = 1'b0;
    step();
    chk("grant after cpu idle", {30'd0, seen_grant}, 32'b01);
    pend[0] = 1'b0;
    apply_aux();

    // Aux write then CPU read-back.
    pend[1] = 1'b1; pwe[1] = 1'b1; paddr[1] = 12'h333; pdata[1] = 4'hA;
    apply_aux();
    step();
    chk("aux write grant", {30'd0, seen_grant}, 32'b10);
    pend[1] = 1'b0;
    apply_aux();
    cpu_rd(12'h333);
    chk("cpu rd 333", {28'd0, cpu_read_data}, 32'hA);
    step();

    // Randomized mixed traffic.
    for (int n = 0; n < 3000; n++) begin
      r = int'($urandom_range(0, 9));
      cpu_write_en = (r < 2) || (r == 4);
      cpu_read_en = (r >= 2) && (r < 5);
      cpu_addr = rand_addr();
      cpu_write_data = DW'($urandom);
      for (int c = 0; c < NCH; c++) begin
        if (!pend[c] && $urandom_range(0, 2) == 0) begin
          pend[c] = 1'b1;
          pwe[c] = 1'($urandom_range(0, 1));
          paddr[c] = rand_addr();
          pdata[c] = DW'($urandom);
        end
      end
      apply_aux();
      step();
      if (last_grant >= 0) pend[last_grant] = 1'b0;
    end
    set_idle();
    for (int c = 0; c < NCH; c++) pend[c] = 1'b0;
    repeat (3) step();

    // Reset in the middle of the sweep restarts it from zero.
    cpu_wr(12'h050, 4'h9);
    cpu_wr(12'h800, 4'h7);
    step();
    do_reset();
    repeat (12'h100) step();
    do_reset();
    while (clear_left > 0) step();
    step();
    cpu_rd(12'h050);
    chk("restart rd 050", {28'd0, cpu_read_data}, 32'd0);
    cpu_rd(12'h800);
    chk("restart rd 800", {28'd0, cpu_read_data}, 32'd0);
    step();

    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
